// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning a shared N-bit register for four writers; grant one cycle after request, write+ack the next.
// Optional `ARB_LOCK_EN: a locked winner keeps search priority for its next arbitration.
module reg_write_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] wdata,
    input  logic [3:0]     lock,
    output logic [3:0]     gnt,
    output logic [3:0]     ack,
    output logic [N-1:0]   q,
    output logic           busy,
    output logic [1:0]     last_src
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [3:0] elig;
    logic       found;
    logic [1:0] pick;
    logic       hold_ptr;

    // A requester acknowledged this cycle sits out one arbitration.
    assign elig = req & ~ack;
    assign busy = (state == GRANT);

`ifdef ARB_LOCK_EN
    assign hold_ptr = lock[win];
`else
    logic lock_unused;
    assign lock_unused = ^lock;
    assign hold_ptr    = 1'b0;
`endif

    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int o = 0; o < 4; o++) begin
            logic [1:0] idx;
            idx = ptr + o[1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            win      <= 2'd0;
            q        <= '0;
            gnt      <= 4'b0000;
            ack      <= 4'b0000;
            last_src <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 4'b0000;
                    if (found) begin
                        state <= GRANT;
                        win   <= pick;
                        gnt   <= 4'b0001 << pick;
                    end
                end
                default: begin
                    q        <= wdata[win*N +: N];
                    ack      <= 4'b0001 << win;
                    last_src <= win;
                    gnt      <= 4'b0000;
                    ptr      <= hold_ptr ? win : win + 2'd1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_reg_write_arbiter;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*N-1:0] wdata;
    logic [3:0]     lock;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [N-1:0]   q;
    logic           busy;
    logic [1:0]     last_src;

    int checks = 0;
    int errors = 0;

    // reference model state: win < 0 means no write in flight
    int       m_win;
    int       m_ptr;
    int       m_last;
    logic [7:0] m_q;
    logic [3:0] m_gnt;
    logic [3:0] m_ack;

    reg_write_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lock(lock),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .last_src(last_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_win = -1; m_ptr = 0; m_last = 0; m_q = 8'h00; m_gnt = 4'b0; m_ack = 4'b0;
        end else if (m_win >= 0) begin
            m_q    = wdata[m_win*N +: N];
            m_ack  = 4'b0;
            m_ack[m_win] = 1'b1;
            m_last = m_win;
            m_ptr  = (m_win + 1) % 4;
`ifdef ARB_LOCK_EN
            if (lock[m_win]) m_ptr = m_win;
`endif
            m_gnt  = 4'b0;
            m_win  = -1;
        end else begin
            int pick;
            pick = -1;
            for (int o = 0; o < 4; o++) begin
                int i;
                i = (m_ptr + o) % 4;
                if (pick < 0 && req[i] && !m_ack[i]) pick = i;
            end
            m_ack = 4'b0;
            if (pick >= 0) begin
                m_win = pick;
                m_gnt = 4'b0;
                m_gnt[pick] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd, input logic [3:0] lk);
        rst = r; req = rq; wdata = wd; lock = lk;
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", {28'd0, gnt}, {28'd0, m_gnt});
        check("ack", {28'd0, ack}, {28'd0, m_ack});
        check("q", {24'd0, q}, {24'd0, m_q});
        check("busy", {31'd0, busy}, {31'd0, m_win >= 0});
        check("last_src", {30'd0, last_src}, m_last);
        check("gnt_ack_excl", {31'd0, (gnt != 0) && (ack != 0)}, 32'd0);
    endtask

    initial begin
        int order[$];
        logic [7:0] qs[$];
        logic [3:0]  rr;
        logic [31:0] wd;
        logic [3:0]  lk;
        logic        r;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_q[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        rst = 1'b1; req = 4'b0; wdata = '0; lock = 4'b0;
        m_win = -1; m_ptr = 0; m_last = 0; m_q = 8'h00; m_gnt = 4'b0; m_ack = 4'b0;

        // reset holds everything quiet even with all requesters asking
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 4'b1111, 32'hFFFF_FFFF, 4'b0);
            check("rst_gnt", {28'd0, gnt}, 32'd0);
            check("rst_q", {24'd0, q}, 32'd0);
        end

        // single request latency
        step(1'b0, 4'b0100, 32'h00A5_0000, 4'b0);
        check("lat_gnt", {28'd0, gnt}, 32'h4);
        step(1'b0, 4'b0100, 32'h00A5_0000, 4'b0);
        check("lat_q", {24'd0, q}, 32'hA5);
        check("lat_ack", {28'd0, ack}, 32'h4);
        check("lat_last", {30'd0, last_src}, 32'd2);

        // round robin with all requesters
        step(1'b1, 4'b0, 32'h0, 4'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b1111, 32'h4433_2211, 4'b0);
            for (int i = 0; i < 4; i++)
                if (ack[i]) begin order.push_back(i); qs.push_back(q); end
        end
        check("rr_count", order.size(), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            check("rr_order", order[i], exp_order[i]);
            check("rr_q", {24'd0, qs[i]}, {24'd0, exp_q[i]});
        end

        // just-acknowledged requester is masked for one cycle
        step(1'b1, 4'b0, 32'h0, 4'b0);
        step(1'b0, 4'b0010, 32'h0000_5500, 4'b0);
        step(1'b0, 4'b0010, 32'h0000_5500, 4'b0);
        check("mask_ack", {28'd0, ack}, 32'h2);
        step(1'b0, 4'b0010, 32'h0000_5500, 4'b0);
        check("mask_gnt", {28'd0, gnt}, 32'h0);
        step(1'b0, 4'b0010, 32'h0000_5500, 4'b0);
        check("regrant", {28'd0, gnt}, 32'h2);

        // reset during GRANT aborts the write and restarts search at 0
        step(1'b1, 4'b0, 32'h0, 4'b0);
        step(1'b0, 4'b1000, 32'h7E00_0000, 4'b0);
        check("abort_pre", {28'd0, gnt}, 32'h8);
        step(1'b1, 4'b1000, 32'h7E00_0000, 4'b0);
        check("abort_q", {24'd0, q}, 32'h0);
        check("abort_ack", {28'd0, ack}, 32'h0);
        step(1'b0, 4'b1001, 32'h7E00_0000, 4'b0);
        check("post_rst_gnt", {28'd0, gnt}, 32'h1);

        // lock scenario: alternation 0,1,0,1 in either build
        step(1'b1, 4'b0, 32'h0, 4'b0);
        order.delete();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 4'b0011, 32'h0000_BBAA, 4'b0001);
            for (int i = 0; i < 4; i++) if (ack[i]) order.push_back(i);
        end
        check("lock_count", order.size(), 32'd4);
        for (int i = 0; i < order.size(); i++) check("lock_order", order[i], i % 2);

        // random traffic
        rr = 4'b0; wd = '0; lk = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 0) begin
                rr = 4'($urandom);
                wd = $urandom;
                lk = 4'($urandom);
            end
            step(r, rr, wd, lk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
